pipe_ctrl: RTL and testbench

Central pipeline controller for the 32-bit RISC-V core. It arbitrates redirect and stall requests from ex, the fetch bus and the interrupt source. It drives the pc's jump and hold inputs, plus the flush and hold levels for if_id and id_ex. It also sequences post-redirect flushing, interrupt acceptance and the fetch-stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_watchdog.sv | 38 +++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: hold levels, FSM states and
// the enable polarities used across the controller slice.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        HoldNone = 3'd0,
        HoldPc   = 3'd1,
        HoldIf   = 3'd2,
        HoldId   = 3'd3
    } hold_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        ERR   = 2'd2
    } state_e;

    localparam logic JumpEnable  = 1'b1;
    localparam logic ResetEnable = 1'b1;

    // Hold levels are ordered, so combining requests is a max().
    function automatic hold_e hold_max(input hold_e a, input hold_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Fetch-stall watchdog: counts consecutive bus-hold cycles, flags the
// cycle in which the limit is hit and keeps a sticky trip indication.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 256
) (
    input  logic i_Clk,
    input  logic i_reset,
    input  logic bus_hold,
    output logic timeout,
    output logic tripped
);

    localparam logic [15:0] Limit = 16'(BUS_TIMEOUT - 1);

    logic [15:0] count;

    assign timeout = bus_hold && (count == Limit);

    // Counter saturates so a long stall after the trip cannot wrap around.
    always_ff @(posedge i_Clk) begin
        if (i_reset == ResetEnable) begin
            count   <= '0;
            tripped <= 1'b0;
        end else begin
            if (!bus_hold) begin
                count <= '0;
            end else if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
            if (timeout) begin
                tripped <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: arbitrates ex redirects, interrupts and fetch
// stalls into pc jump/hold controls and if_id/id_ex flush/hold levels.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 256
) (
    input  logic        i_Clk,
    input  logic        i_reset,
    input  logic        i_ex_jump_flag,
    input  logic [31:0] i_ex_jump_addr,
    input  logic        i_ex_hold_flag,
    input  logic [31:0] i_ex_pc,
    input  logic        i_bus_hold,
    input  logic        i_int_req,
    input  logic [31:0] i_int_addr,
    output logic        o_int_ack,
    output logic [31:0] o_int_epc,
    output logic        o_jump_flag,
    output logic [31:0] o_jump_addr,
    output logic [2:0]  o_hold_flag,
    output logic        o_flush,
    output logic        o_bus_err
);

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

    state_e     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic       bus_timeout, bus_tripped;
    logic       take_int, jump_req;
    hold_e      hold_level;

    stall_watchdog #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_watchdog (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .bus_hold(i_bus_hold),
        .timeout (bus_timeout),
        .tripped (bus_tripped)
    );

    always_ff @(posedge i_Clk) begin
        if (i_reset == ResetEnable) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // A watchdog trip in the same cycle suppresses any redirect.
    always_comb begin
        take_int = (state == RUN) && i_int_req && !i_ex_hold_flag
                   && !i_bus_hold && !i_reset;
        jump_req = (take_int || (i_ex_jump_flag && (state != ERR)))
                   && !bus_timeout && !i_reset;
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        if (bus_timeout) begin
            state_next = ERR;
        end else begin
            case (state)
                RUN: begin
                    if (jump_req) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FlushLoad;
                    end
                end
                FLUSH: begin
                    if (jump_req) begin
                        flush_cnt_next = FlushLoad;
                    end else if (i_ex_hold_flag) begin
                        flush_cnt_next = flush_cnt;
                    end else if (flush_cnt == 3'd0) begin
                        state_next = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - 3'd1;
                    end
                end
                ERR:     state_next = ERR;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        hold_level  = HoldNone;
        o_int_ack   = 1'b0;
        o_int_epc   = '0;
        o_jump_flag = 1'b0;
        o_jump_addr = '0;
        o_hold_flag = '0;
        o_flush     = 1'b0;
        o_bus_err   = 1'b0;
        if (!i_reset) begin
            if (i_bus_hold) begin
                hold_level = hold_max(hold_level, HoldPc);
            end
            if (i_ex_hold_flag || (state == ERR)) begin
                hold_level = hold_max(hold_level, HoldId);
            end
            o_hold_flag = hold_level;
            o_flush     = (state == FLUSH);
            o_bus_err   = bus_tripped;
            if (jump_req) begin
                o_jump_flag = JumpEnable;
                o_jump_addr = take_int ? i_int_addr : i_ex_jump_addr;
            end
            if (take_int) begin
                o_int_ack = 1'b1;
                o_int_epc = i_ex_jump_flag ? i_ex_jump_addr : (i_ex_pc + 32'd4);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs into a queue; a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    typedef struct packed {
        logic        rst;
        logic        jf;
        logic [31:0] ja;
        logic        hf;
        logic [31:0] pc;
        logic        bh;
        logic        ir;
        logic [31:0] ia;
    } in_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] epc;
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  hold;
        logic        flush;
        logic        err;
    } exp_t;

    logic        clk;
    logic        i_reset;
    logic        i_ex_jump_flag;
    logic [31:0] i_ex_jump_addr;
    logic        i_ex_hold_flag;
    logic [31:0] i_ex_pc;
    logic        i_bus_hold;
    logic        i_int_req;
    logic [31:0] i_int_addr;
    logic        o_int_ack;
    logic [31:0] o_int_epc;
    logic        o_jump_flag;
    logic [31:0] o_jump_addr;
    logic [2:0]  o_hold_flag;
    logic        o_flush;
    logic        o_bus_err;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    pipe_ctrl #(
        .FLUSH_CYCLES(2),
        .BUS_TIMEOUT (4)
    ) dut (
        .i_Clk         (clk),
        .i_reset       (i_reset),
        .i_ex_jump_flag(i_ex_jump_flag),
        .i_ex_jump_addr(i_ex_jump_addr),
        .i_ex_hold_flag(i_ex_hold_flag),
        .i_ex_pc       (i_ex_pc),
        .i_bus_hold    (i_bus_hold),
        .i_int_req     (i_int_req),
        .i_int_addr    (i_int_addr),
        .o_int_ack     (o_int_ack),
        .o_int_epc     (o_int_epc),
        .o_jump_flag   (o_jump_flag),
        .o_jump_addr   (o_jump_addr),
        .o_hold_flag   (o_hold_flag),
        .o_flush       (o_flush),
        .o_bus_err     (o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic rst, input logic jf, input logic [31:0] ja,
                                  input logic hf, input logic [31:0] pc, input logic bh,
                                  input logic ir, input logic [31:0] ia);
        in_t s;
        s = '{rst: rst, jf: jf, ja: ja, hf: hf, pc: pc, bh: bh, ir: ir, ia: ia};
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic ack, input logic [31:0] epc, input logic jf,
                                    input logic [31:0] ja, input logic [2:0] hold,
                                    input logic flush, input logic err);
        exp_t e;
        e = '{ack: ack, epc: epc, jf: jf, ja: ja, hold: hold, flush: flush, err: err};
        return e;
    endfunction

    task automatic applyStimulus(input in_t s, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        i_reset        = s.rst;
        i_ex_jump_flag = s.jf;
        i_ex_jump_addr = s.ja;
        i_ex_hold_flag = s.hf;
        i_ex_pc        = s.pc;
        i_bus_hold     = s.bh;
        i_int_req      = s.ir;
        i_int_addr     = s.ia;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput();
        exp_t  e;
        exp_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{ack: o_int_ack, epc: o_int_epc, jf: o_jump_flag, ja: o_jump_addr,
               hold: o_hold_flag, flush: o_flush, err: o_bus_err};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got ack=%0b epc=%h jf=%0b ja=%h hold=%0d flush=%0b err=%0b; expected ack=%0b epc=%h jf=%0b ja=%h hold=%0d flush=%0b err=%0b",
                     nm, a.ack, a.epc, a.jf, a.ja, a.hold, a.flush, a.err,
                     e.ack, e.epc, e.jf, e.ja, e.hold, e.flush, e.err);
        end
    endtask

    // Monitor: compares whatever the stimulus side has queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput();
        end
    end

    initial begin
        exp_t zero;
        exp_t fl;
        in_t  idle;
        zero = mk_exp(0, 0, 0, 0, 0, 0, 0);
        fl   = mk_exp(0, 0, 0, 0, 0, 1, 0);
        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0);

        i_reset = 1'b1; i_ex_jump_flag = 1'b0; i_ex_jump_addr = '0; i_ex_hold_flag = 1'b0;
        i_ex_pc = '0; i_bus_hold = 1'b0; i_int_req = 1'b0; i_int_addr = '0;

        for (int i = 0; i < 3; i++)
            applyStimulus(mk_in(1, 1, 32'h100, 0, 0, 0, 0, 0), zero, "reset_jump");
        applyStimulus(idle, zero, "after_reset");

        applyStimulus(mk_in(0, 1, 32'h100, 0, 0, 0, 0, 0), mk_exp(0, 0, 1, 32'h100, 0, 0, 0), "jump_100");
        applyStimulus(idle, fl, "jump_flush1");
        applyStimulus(idle, fl, "jump_flush2");
        applyStimulus(idle, zero, "jump_done");

        applyStimulus(mk_in(0, 0, 0, 0, 32'h40, 0, 1, 32'h200), mk_exp(1, 32'h44, 1, 32'h200, 0, 0, 0), "int_ack");
        applyStimulus(mk_in(0, 0, 0, 0, 32'h40, 0, 1, 32'h200), fl, "int_no_reack");
        applyStimulus(idle, fl, "int_flush2");
        applyStimulus(idle, zero, "int_done");

        applyStimulus(mk_in(0, 1, 32'h80, 0, 32'h40, 0, 1, 32'h200), mk_exp(1, 32'h80, 1, 32'h200, 0, 0, 0), "int_beats_jump");
        applyStimulus(idle, fl, "ibj_flush1");
        applyStimulus(idle, fl, "ibj_flush2");
        applyStimulus(idle, zero, "ibj_done");

        applyStimulus(mk_in(0, 0, 0, 1, 32'h50, 0, 1, 32'h300), mk_exp(0, 0, 0, 0, 3, 0, 0), "int_held1");
        applyStimulus(mk_in(0, 0, 0, 1, 32'h50, 0, 1, 32'h300), mk_exp(0, 0, 0, 0, 3, 0, 0), "int_held2");
        applyStimulus(mk_in(0, 0, 0, 0, 32'h50, 0, 1, 32'h300), mk_exp(1, 32'h54, 1, 32'h300, 0, 0, 0), "int_after_hold");
        applyStimulus(idle, fl, "iah_flush1");
        applyStimulus(idle, fl, "iah_flush2");
        applyStimulus(idle, zero, "iah_done");

        applyStimulus(mk_in(0, 1, 32'h400, 0, 0, 0, 0, 0), mk_exp(0, 0, 1, 32'h400, 0, 0, 0), "jump_400");
        applyStimulus(mk_in(0, 0, 0, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 3, 1, 0), "frozen1");
        applyStimulus(mk_in(0, 0, 0, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 3, 1, 0), "frozen2");
        applyStimulus(idle, fl, "unfrozen1");
        applyStimulus(idle, fl, "unfrozen2");
        applyStimulus(idle, zero, "unfrozen_done");

        applyStimulus(mk_in(0, 1, 32'h500, 0, 0, 0, 0, 0), mk_exp(0, 0, 1, 32'h500, 0, 0, 0), "jump_500");
        applyStimulus(idle, fl, "reload_flush1");
        applyStimulus(mk_in(0, 1, 32'h600, 0, 0, 0, 0, 0), mk_exp(0, 0, 1, 32'h600, 0, 1, 0), "jump_in_flush");
        applyStimulus(idle, fl, "reload_flush2");
        applyStimulus(idle, fl, "reload_flush3");
        applyStimulus(idle, zero, "reload_done");

        applyStimulus(mk_in(0, 1, 32'h700, 0, 0, 1, 0, 0), mk_exp(0, 0, 1, 32'h700, 1, 0, 0), "bus3_jump");
        applyStimulus(mk_in(0, 0, 0, 0, 0, 1, 0, 0), mk_exp(0, 0, 0, 0, 1, 1, 0), "bus3_c2");
        applyStimulus(mk_in(0, 0, 0, 0, 0, 1, 0, 0), mk_exp(0, 0, 0, 0, 1, 1, 0), "bus3_c3");
        applyStimulus(idle, zero, "bus3_drop");
        for (int i = 0; i < 3; i++)
            applyStimulus(mk_in(0, 0, 0, 0, 0, 1, 0, 0), mk_exp(0, 0, 0, 0, 1, 0, 0), "bus_cleared");
        applyStimulus(idle, zero, "bus_cleared_drop");

        for (int i = 0; i < 4; i++)
            applyStimulus(mk_in(0, 0, 0, 0, 0, 1, 0, 0), mk_exp(0, 0, 0, 0, 1, 0, 0), "bus4");
        applyStimulus(mk_in(0, 1, 32'h800, 0, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 3, 0, 1), "err_jump_ignored");
        applyStimulus(mk_in(0, 0, 0, 0, 32'h60, 0, 1, 32'h900), mk_exp(0, 0, 0, 0, 3, 0, 1), "err_no_int");
        applyStimulus(mk_in(1, 0, 0, 0, 0, 0, 0, 0), zero, "err_reset");
        applyStimulus(idle, zero, "post_err_idle");
        applyStimulus(mk_in(0, 1, 32'h900, 0, 0, 0, 0, 0), mk_exp(0, 0, 1, 32'h900, 0, 0, 0), "post_err_jump");
        applyStimulus(idle, fl, "post_err_flush1");
        applyStimulus(idle, fl, "post_err_flush2");
        applyStimulus(idle, zero, "post_err_done");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d unchecked vectors, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
